// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline plus the EX/MEM register.
//
// Decodes the ALU operation from aluop/funct and selects ALU operand B
// (immediate or rt). It computes the ALU result, the branch target
// (PC+4 + imm<<2) and the destination register, then registers these results
// with the MEM/WB controls into EX/MEM. Latency is one cycle.
//
// Optional build macro: EX_MULT_EN
//   Adds a multi-cycle unsigned shift-add MULT (aluop=10, funct=0x18) that
//   raises busy_out while it runs. Without it, funct 0x18 decodes as an
//   unknown funct (result 0) and busy_out is tied low.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-low reset
//   valid_in             ID/EX slot holds a real instruction
//   addp4_in             PC+4
//   read_data1_in        rs value
//   read_data2_in        rt value
//   signext_in           sign-extended immediate
//   funct_in             instr[5:0]
//   rt_in, rd_in         instr[20:16], instr[15:11]
//   *_in controls        wr_en/regdst/pcsrc/memtoreg/mem_read/memwrite/alusrc/jump
//   aluop_in             ALU op class
//   stall_in             hold EX/MEM
//   flush_in             squash the instruction entering EX/MEM
//   alu_result, write_data, add_out, zero_out, branch_taken, write_reg,
//   wr_en, memtoreg, mem_read, memwrite, jump, valid_out   registered EX/MEM
//   busy_out             EX occupied, upstream must hold ID/EX
module ex_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REGW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] addp4_in,
    input  logic [WIDTH-1:0] read_data1_in,
    input  logic [WIDTH-1:0] read_data2_in,
    input  logic [WIDTH-1:0] signext_in,
    input  logic [5:0]       funct_in,
    input  logic [REGW-1:0]  rt_in,
    input  logic [REGW-1:0]  rd_in,
    input  logic             wr_en_in,
    input  logic             regdst_in,
    input  logic             pcsrc_in,
    input  logic             memtoreg_in,
    input  logic             mem_read_in,
    input  logic             memwrite_in,
    input  logic             alusrc_in,
    input  logic             jump_in,
    input  logic [1:0]       aluop_in,
    input  logic             stall_in,
    input  logic             flush_in,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] add_out,
    output logic             zero_out,
    output logic             branch_taken,
    output logic [REGW-1:0]  write_reg,
    output logic             wr_en,
    output logic             memtoreg,
    output logic             mem_read,
    output logic             memwrite,
    output logic             jump,
    output logic             valid_out,
    output logic             busy_out
);

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    // ------------------------------------------------------------------
    // Combinational ALU
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic             slt_bit;
    logic [WIDTH-1:0] branch_target;

    always_comb begin
        op_b    = alusrc_in ? signext_in : read_data2_in;
        slt_bit = $signed(read_data1_in) < $signed(op_b);
        alu_res = '0;
        case (aluop_in)
            2'b00: alu_res = read_data1_in + op_b;
            2'b01: alu_res = read_data1_in - op_b;
            2'b11: alu_res = read_data1_in | op_b;
            default: begin
                case (funct_in)
                    F_ADD:   alu_res = read_data1_in + op_b;
                    F_SUB:   alu_res = read_data1_in - op_b;
                    F_AND:   alu_res = read_data1_in & op_b;
                    F_OR:    alu_res = read_data1_in | op_b;
                    F_NOR:   alu_res = ~(read_data1_in | op_b);
                    F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
                    default: alu_res = '0;
                endcase
            end
        endcase
        branch_target = addp4_in + (signext_in << 2);
    end

    // load_en: EX/MEM may capture this cycle (flush is handled separately
    // and always wins). load_result: value written to alu_result.
    logic             load_en;
    logic [WIDTH-1:0] load_result;
    logic             busy;

`ifdef EX_MULT_EN
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] CNT_LAST = 6'(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] prod_q, prod_d;

    logic             mult_req;
    logic [WIDTH-1:0] step_mcand;
    logic [WIDTH-1:0] step_mplier;
    logic [WIDTH-1:0] step_prod;
    logic [WIDTH-1:0] step_sum;

    // The capture edge in IDLE already performs iteration 1 straight from the
    // operands, so WIDTH iterations complete on the WIDTH-th edge.
    always_comb begin
        mult_req = valid_in && (aluop_in == 2'b10) && (funct_in == F_MULT);
        if (state_q == S_IDLE) begin
            step_mcand  = read_data1_in;
            step_mplier = op_b;
            step_prod   = '0;
        end else begin
            step_mcand  = mcand_q;
            step_mplier = mplier_q;
            step_prod   = prod_q;
        end
        step_sum = step_prod + (step_mplier[0] ? step_mcand : '0);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        busy        = 1'b0;
        load_en     = 1'b0;
        load_result = alu_res;
        case (state_q)
            S_IDLE: begin
                if (mult_req) begin
                    busy = 1'b1;
                    if (!flush_in) begin
                        state_d  = S_MUL;
                        cnt_d    = 6'd1;
                        mcand_d  = step_mcand << 1;
                        mplier_d = step_mplier >> 1;
                        prod_d   = step_sum;
                    end
                end else begin
                    load_en = !stall_in;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (flush_in) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // product already complete, waiting out a stall
                    if (!stall_in) begin
                        load_en     = 1'b1;
                        load_result = prod_q;
                        state_d     = S_IDLE;
                    end
                end else begin
                    cnt_d    = cnt_q + 6'd1;
                    mcand_d  = step_mcand << 1;
                    mplier_d = step_mplier >> 1;
                    prod_d   = step_sum;
                    if ((cnt_q + 6'd1 == CNT_LAST) && !stall_in) begin
                        load_en     = 1'b1;
                        load_result = step_sum;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end
`else
    always_comb begin
        busy        = 1'b0;
        load_en     = !stall_in;
        load_result = alu_res;
    end
`endif

    assign busy_out = busy;

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_result_q, alu_result_d;
    logic [WIDTH-1:0] write_data_q, write_data_d;
    logic [WIDTH-1:0] add_out_q, add_out_d;
    logic             zero_q, zero_d;
    logic             branch_taken_q, branch_taken_d;
    logic [REGW-1:0]  write_reg_q, write_reg_d;
    logic             wr_en_q, wr_en_d;
    logic             memtoreg_q, memtoreg_d;
    logic             mem_read_q, mem_read_d;
    logic             memwrite_q, memwrite_d;
    logic             jump_q, jump_d;
    logic             valid_q, valid_d;

    always_comb begin
        alu_result_d   = alu_result_q;
        write_data_d   = write_data_q;
        add_out_d      = add_out_q;
        zero_d         = zero_q;
        branch_taken_d = branch_taken_q;
        write_reg_d    = write_reg_q;
        wr_en_d        = wr_en_q;
        memtoreg_d     = memtoreg_q;
        mem_read_d     = mem_read_q;
        memwrite_d     = memwrite_q;
        jump_d         = jump_q;
        valid_d        = valid_q;
        if (flush_in) begin
            // squash controls only; data fields keep their last value
            valid_d        = 1'b0;
            wr_en_d        = 1'b0;
            memtoreg_d     = 1'b0;
            mem_read_d     = 1'b0;
            memwrite_d     = 1'b0;
            jump_d         = 1'b0;
            branch_taken_d = 1'b0;
        end else if (load_en) begin
            alu_result_d   = load_result;
            write_data_d   = read_data2_in;
            add_out_d      = branch_target;
            zero_d         = (load_result == '0);
            branch_taken_d = pcsrc_in && (load_result == '0) && valid_in;
            write_reg_d    = regdst_in ? rd_in : rt_in;
            wr_en_d        = wr_en_in && valid_in;
            memtoreg_d     = memtoreg_in && valid_in;
            mem_read_d     = mem_read_in && valid_in;
            memwrite_d     = memwrite_in && valid_in;
            jump_d         = jump_in && valid_in;
            valid_d        = valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_result_q   <= '0;
            write_data_q   <= '0;
            add_out_q      <= '0;
            zero_q         <= 1'b0;
            branch_taken_q <= 1'b0;
            write_reg_q    <= '0;
            wr_en_q        <= 1'b0;
            memtoreg_q     <= 1'b0;
            mem_read_q     <= 1'b0;
            memwrite_q     <= 1'b0;
            jump_q         <= 1'b0;
            valid_q        <= 1'b0;
        end else begin
            alu_result_q   <= alu_result_d;
            write_data_q   <= write_data_d;
            add_out_q      <= add_out_d;
            zero_q         <= zero_d;
            branch_taken_q <= branch_taken_d;
            write_reg_q    <= write_reg_d;
            wr_en_q        <= wr_en_d;
            memtoreg_q     <= memtoreg_d;
            mem_read_q     <= mem_read_d;
            memwrite_q     <= memwrite_d;
            jump_q         <= jump_d;
            valid_q        <= valid_d;
        end
    end

    assign alu_result   = alu_result_q;
    assign write_data   = write_data_q;
    assign add_out      = add_out_q;
    assign zero_out     = zero_q;
    assign branch_taken = branch_taken_q;
    assign write_reg    = write_reg_q;
    assign wr_en        = wr_en_q;
    assign memtoreg     = memtoreg_q;
    assign mem_read     = mem_read_q;
    assign memwrite     = memwrite_q;
    assign jump         = jump_q;
    assign valid_out    = valid_q;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline; sits directly downstream of the ID/EX register (dflipflop23) and consumes its outputs.
- Decodes ALU control from aluop/funct, selects the ALU B operand, computes the ALU result, the branch target and the destination register.
- Registers all results plus MEM/WB controls into the EX/MEM pipeline register.
- Registered outputs add_out and branch_taken drive the PC mux (add_out34/pcsrc34 path).

Parameters:
- WIDTH, 32, datapath width.
- REGW, 5, register-index width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-low reset
valid_in  in  1  ID/EX slot holds a real instruction
addp4_in  in  WIDTH  PC+4 from ID/EX
read_data1_in  in  WIDTH  rs value
read_data2_in  in  WIDTH  rt value
signext_in  in  WIDTH  sign-extended immediate
funct_in  in  6  instr[5:0]
rt_in  in  REGW  instr[20:16]
rd_in  in  REGW  instr[15:11]
wr_en_in, regdst_in, pcsrc_in, memtoreg_in, mem_read_in, memwrite_in, alusrc_in, jump_in  in  1 each  controller signals via ID/EX
aluop_in  in  2  ALU op class
stall_in  in  1  hold EX/MEM (MEM-side stall)
flush_in  in  1  squash the instruction entering EX/MEM
alu_result  out  WIDTH  registered ALU result
write_data  out  WIDTH  registered read_data2_in (store data)
add_out  out  WIDTH  registered branch target
zero_out  out  1  registered ALU-result==0
branch_taken  out  1  registered pcsrc & zero & valid
write_reg  out  REGW  registered destination
wr_en, memtoreg, mem_read, memwrite, jump  out  1 each  registered controls
valid_out  out  1  EX/MEM slot valid
busy_out  out  1  EX occupied; upstream must hold ID/EX

Behaviour:
- Reset (rst=0 at an edge): every output = 0; FSM = IDLE. Takes priority over flush and stall.
- Operand B = alusrc_in ? signext_in : read_data2_in.
- aluop=00: ADD. aluop=01: SUB. aluop=11: OR.
- aluop=10, by funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT (signed, result 1/0). Any other funct yields result 0.
- Arithmetic wraps modulo 2^WIDTH; no overflow trap.
- write_reg = regdst_in ? rd_in : rt_in.
- add_out = addp4_in + (signext_in << 2), wrapping.
- branch_taken = pcsrc_in & zero & valid_in, registered.
- Latency: 1 cycle from ID/EX presentation to EX/MEM outputs.
- Priority at each edge: rst > flush_in > stall_in/busy > load.
- flush_in: valid_out and all control outputs (wr_en, mem_read, memwrite, memtoreg, jump, branch_taken) = 0. Data outputs hold.
- stall_in=1 (no flush): all outputs hold.
- valid_in=0 while loading: data loads; control outputs and valid_out load as 0.
- Simultaneous flush_in and stall_in: flush wins.
- busy_out = 0 whenever MULT_EN is absent.

Optional Feature:
Macro: EX_MULT_EN.
- Defined: aluop=10 with funct 0x18 is MULT, producing the low WIDTH bits of an unsigned shift-add product.
- FSM IDLE->MUL: busy_out rises combinationally when a valid MULT is presented in IDLE and stays high through MUL.
- MUL runs WIDTH iterations, one per cycle, using a 6-bit counter.
- On the WIDTH-th edge the EX/MEM register loads the product, write_reg and controls; FSM returns to IDLE and busy_out drops.
- If stall_in is high at completion, FSM holds in MUL with the counter at WIDTH until stall_in clears, then loads.
- flush_in during MUL aborts the multiply: FSM -> IDLE, valid_out = 0.
- rst during MUL: FSM -> IDLE, outputs 0.
- Not defined: funct 0x18 is an unknown funct (result 0); busy_out tied 0; no FSM.

Test Plan:
- rst=0 for 2 cycles with nonzero inputs -> all outputs 0, valid_out=0. Release rst -> first load on the next edge.
- R-type: rd1=5, rd2=7, aluop=10, funct=0x20, regdst=1, rd=3, wr_en=1, valid=1 -> next cycle alu_result=12, write_reg=3, wr_en=1, valid_out=1. Repeat with funct=0x2A, rd1=0xFFFFFFFF, rd2=1 -> alu_result=1.
- beq: rd1=rd2=0x10, aluop=01, pcsrc=1, addp4=0x104, signext=0xFFFFFFFE -> add_out=0xFC, zero_out=1, branch_taken=1. Same with rd2=0x11 -> branch_taken=0.
- lw: alusrc=1, rd1=0x1000, signext=0xFFFFFFFC, aluop=00, regdst=0, rt=8, mem_read=1 -> alu_result=0xFFC, write_reg=8, mem_read=1.
- Load add, then stall_in=1 for 3 cycles with changing inputs -> outputs frozen. Then flush_in=1 together with stall_in=1 -> valid_out=0, wr_en=0, mem_read=0.
- EX_MULT_EN: rd1=0x00010003, rd2=5, funct=0x18 -> busy_out=1 for 32 cycles, then alu_result=0x0005000F, valid_out=1. Repeat with flush_in at iteration 10 -> valid_out=0, busy_out=0 next cycle.
